hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of consecutive cycles flush_o is asserted per taken branch; legal range 1..15.
REQ-002 SHALL have port clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n_i  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports dec_valid_i  in  1, dec_rn_addr_i  in  4, dec_rn_use_i  in  1, dec_rm_addr_i  in  4, dec_rm_use_i  in  1  decode-stage instruction valid, source register addresses and their use flags.
REQ-005 SHALL have ports ex_valid_i  in  1, ex_rd_addr_i  in  4, ex_is_load_i  in  1, ex_do_write_i  in  1  execute-stage valid, destination, load flag and register-write flag.
REQ-006 SHALL have port branch_taken_i  in  1  branch taken (condition met) in execute this cycle.
REQ-007 SHALL have port mem_busy_i  in  1  data memory cannot complete this cycle.
REQ-008 SHALL have ports stall_fetch_o, stall_decode_o, stall_execute_o  out  1 each  hold the corresponding pipeline registers.
REQ-009 SHALL have ports bubble_o  out  1  (insert invalid instruction into execute) and flush_o  out  1  (invalidate fetch/decode contents).
REQ-010 SHALL have ports state_o  out  2  (RUN=0, MEM_WAIT=1, FLUSH=2), stall_count_o  out  16, flush_count_o  out  16.

Function
REQ-011 SHALL define load_hazard = ex_valid_i & ex_is_load_i & ex_do_write_i & dec_valid_i & ((dec_rn_use_i & dec_rn_addr_i==ex_rd_addr_i) | (dec_rm_use_i & dec_rm_addr_i==ex_rd_addr_i)).
REQ-012 SHALL produce stall_*, bubble_o, flush_o combinationally from the registered state and current inputs (same-cycle response); state, flush down-counter and statistics counters are registered.
REQ-013 SHALL, in RUN, apply priority mem_busy_i > (branch_taken_i & ex_valid_i) > load_hazard > idle.
REQ-014 SHALL, in RUN with mem_busy_i=1: all three stalls=1, bubble_o=0, flush_o=0; next state MEM_WAIT.
REQ-015 SHALL, in RUN with taken valid branch: flush_o=1, stalls=0, bubble_o=0; flush_count_o increments; if FLUSH_CYCLES>1 next state FLUSH with down-counter loaded with FLUSH_CYCLES-1, else remain RUN.
REQ-016 SHALL, in RUN with load_hazard only: stall_fetch_o=stall_decode_o=bubble_o=1, stall_execute_o=0; remain RUN (one-cycle bubble; hazard clears since execute then holds the bubble).
REQ-017 SHALL, in RUN with no event, drive all control outputs 0.
REQ-018 SHALL, in MEM_WAIT: all three stalls=1 while mem_busy_i=1; on the first cycle mem_busy_i=0, outputs all 0 and next state RUN; branch_taken_i and load_hazard ignored in MEM_WAIT.
REQ-019 SHALL, in FLUSH: flush_o=1, bubble_o=0; if mem_busy_i=0, stalls=0 and counter decrements, returning to RUN after the cycle in which counter equals 1; if mem_busy_i=1, all stalls=1 and counter holds.
REQ-020 SHALL ignore branch_taken_i and load_hazard in FLUSH (flushed instructions are invalid).
REQ-021 SHALL increment stall_count_o every cycle stall_fetch_o=1, saturating at 0xFFFF; flush_count_o saturates at 0xFFFF.
REQ-022 SHALL treat ex_valid_i=0 as suppressing both branch and load-hazard detection.

Reset
REQ-023 SHALL, on a rising edge with reset_n_i=0, set state RUN, down-counter 0, stall_count_o=0, flush_count_o=0.
REQ-024 SHALL force stall_*, bubble_o, flush_o to 0 in every cycle reset_n_i=0, including reset asserted mid-FLUSH or mid-MEM_WAIT; first cycle after release behaves as RUN.

Verification
REQ-025 SHALL cover: load r3 in execute, decode uses rn=r3 -> one cycle stall_fetch/decode/bubble=1, stall_count_o=1, next cycle all 0.
REQ-026 SHALL cover: taken branch, FLUSH_CYCLES=2 -> flush_o=1 for exactly 2 cycles, state_o 0->2->0, flush_count_o=1.
REQ-027 SHALL cover: mem_busy_i high 3 cycles coincident with taken branch -> stalls=1 for 3 cycles, flush_o=0, state_o=1; branch re-asserted after -> flush sequence.
REQ-028 SHALL cover: mem_busy_i asserted during FLUSH cycle 1 for 2 cycles -> flush_o held 1 for 4 total cycles, stalls=1 during the busy cycles.
REQ-029 SHALL cover: reset_n_i=0 in FLUSH -> all outputs 0 same cycle; after release state_o=0, counters 0.
REQ-030 SHALL cover: load hazard with ex_valid_i=0 or dec_rn_use_i=0 -> no stall; stall_count_o preloaded to 0xFFFF stays 0xFFFF on further stalls.

Source files
------------

// File: rtl/hazard_if.sv
// Pipeline-to-hazard-controller signal bundle: decode/execute status in,
// stall/bubble/flush control and observability counters out.
interface hazard_if;
  logic        dec_valid_i;
  logic [3:0]  dec_rn_addr_i;
  logic        dec_rn_use_i;
  logic [3:0]  dec_rm_addr_i;
  logic        dec_rm_use_i;
  logic        ex_valid_i;
  logic [3:0]  ex_rd_addr_i;
  logic        ex_is_load_i;
  logic        ex_do_write_i;
  logic        branch_taken_i;
  logic        mem_busy_i;

  logic        stall_fetch_o;
  logic        stall_decode_o;
  logic        stall_execute_o;
  logic        bubble_o;
  logic        flush_o;
  logic [1:0]  state_o;
  logic [15:0] stall_count_o;
  logic [15:0] flush_count_o;

  // The pipeline side drives status and consumes control.
  modport master (
    output dec_valid_i, dec_rn_addr_i, dec_rn_use_i, dec_rm_addr_i, dec_rm_use_i,
           ex_valid_i, ex_rd_addr_i, ex_is_load_i, ex_do_write_i,
           branch_taken_i, mem_busy_i,
    input  stall_fetch_o, stall_decode_o, stall_execute_o, bubble_o, flush_o,
           state_o, stall_count_o, flush_count_o
  );

  modport slave (
    input  dec_valid_i, dec_rn_addr_i, dec_rn_use_i, dec_rm_addr_i, dec_rm_use_i,
           ex_valid_i, ex_rd_addr_i, ex_is_load_i, ex_do_write_i,
           branch_taken_i, mem_busy_i,
    output stall_fetch_o, stall_decode_o, stall_execute_o, bubble_o, flush_o,
           state_o, stall_count_o, flush_count_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and memory-wait
// stalls with a small RUN/MEM_WAIT/FLUSH FSM and saturating statistics.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  hazard_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] stall_count_q, flush_count_q;

  logic load_hazard;
  logic branch_hit;
  logic stall_all, stall_front, bubble, flush, count_flush;
  logic stall_fetch;

  assign load_hazard = bus.ex_valid_i & bus.ex_is_load_i & bus.ex_do_write_i & bus.dec_valid_i &
                       ((bus.dec_rn_use_i & (bus.dec_rn_addr_i == bus.ex_rd_addr_i)) |
                        (bus.dec_rm_use_i & (bus.dec_rm_addr_i == bus.ex_rd_addr_i)));

  assign branch_hit = bus.branch_taken_i & bus.ex_valid_i;

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    stall_all   = 1'b0;
    stall_front = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    count_flush = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.mem_busy_i) begin
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
        end else if (branch_hit) begin
          flush       = 1'b1;
          count_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = 4'(FLUSH_CYCLES - 1);
          end
        end else if (load_hazard) begin
          // Execute receives the bubble next cycle, so the hazard self-clears.
          stall_front = 1'b1;
          bubble      = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (bus.mem_busy_i) stall_all = 1'b1;
        else                state_d   = RUN;
      end

      FLUSH: begin
        flush = 1'b1;
        if (bus.mem_busy_i) begin
          stall_all = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
          if (flush_cnt_q == 4'd1) state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // Control outputs are forced quiet during reset regardless of current state.
  assign stall_fetch         = reset_n_i & (stall_all | stall_front);
  assign bus.stall_fetch_o   = stall_fetch;
  assign bus.stall_decode_o  = reset_n_i & (stall_all | stall_front);
  assign bus.stall_execute_o = reset_n_i & stall_all;
  assign bus.bubble_o        = reset_n_i & bubble;
  assign bus.flush_o         = reset_n_i & flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= RUN;
      flush_cnt_q   <= 4'd0;
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (stall_fetch && stall_count_q != 16'hFFFF)
        stall_count_q <= stall_count_q + 16'd1;
      if (count_flush && flush_count_q != 16'hFFFF)
        flush_count_q <= flush_count_q + 16'd1;
    end
  end

  assign bus.state_o       = state_q;
  assign bus.stall_count_o = stall_count_q;
  assign bus.flush_count_o = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with FLUSH_CYCLES=2.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  hazard_if hif();

  hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (hif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Applies one cycle of inputs, checks the same-cycle control vector
  // {stall_fetch, stall_decode, stall_execute, bubble, flush} at the falling
  // edge, then steps past the rising edge.
  task automatic cyc(input string tag, input logic busy, input logic br, input logic exv,
                     input logic ld, input logic rn_use, input logic [4:0] exp);
    hif.dec_valid_i    = 1'b1;
    hif.dec_rn_addr_i  = 4'd3;
    hif.dec_rn_use_i   = rn_use;
    hif.dec_rm_addr_i  = 4'd7;
    hif.dec_rm_use_i   = 1'b1;
    hif.ex_valid_i     = exv;
    hif.ex_rd_addr_i   = 4'd3;
    hif.ex_is_load_i   = ld;
    hif.ex_do_write_i  = 1'b1;
    hif.branch_taken_i = br;
    hif.mem_busy_i     = busy;
    @(negedge clk);
    check(tag, 32'({hif.stall_fetch_o, hif.stall_decode_o, hif.stall_execute_o,
                    hif.bubble_o, hif.flush_o}), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic regs(input string tag, input logic [1:0] st, input logic [15:0] sc,
                      input logic [15:0] fc);
    check({tag, "_state"}, 32'(hif.state_o), 32'(st));
    check({tag, "_scnt"}, 32'(hif.stall_count_o), 32'(sc));
    check({tag, "_fcnt"}, 32'(hif.flush_count_o), 32'(fc));
  endtask

  initial begin
    rst_n = 1'b0;
    // Reset with a live load hazard and memory wait: all control must stay 0.
    cyc("rst_hz",   0, 0, 1, 1, 1, 5'b00000);
    cyc("rst_busy", 1, 1, 1, 1, 1, 5'b00000);
    regs("reset", 2'd0, 16'd0, 16'd0);
    rst_n = 1'b1;

    cyc("idle", 0, 0, 1, 0, 1, 5'b00000);

    // Load r3 in execute, decode reads r3 through rn.
    cyc("load_hz", 0, 0, 1, 1, 1, 5'b11010);
    regs("load_hz", 2'd0, 16'd1, 16'd0);
    cyc("hz_exv0",   0, 0, 0, 1, 1, 5'b00000);
    cyc("hz_nouse",  0, 0, 1, 1, 0, 5'b00000);
    cyc("br_exv0",   0, 1, 0, 0, 1, 5'b00000);
    regs("no_hz", 2'd0, 16'd1, 16'd0);

    // Taken branch: two flush cycles; branch/hazard in FLUSH are ignored.
    cyc("br", 0, 1, 1, 0, 1, 5'b00001);
    regs("br", 2'd2, 16'd1, 16'd1);
    cyc("br_flush2", 0, 1, 1, 1, 1, 5'b00001);
    regs("br_flush2", 2'd0, 16'd1, 16'd1);
    cyc("br_after", 0, 0, 1, 0, 1, 5'b00000);

    // Memory busy for 3 cycles beats a coincident taken branch.
    cyc("busy1", 1, 1, 1, 0, 1, 5'b11100);
    regs("busy1", 2'd1, 16'd2, 16'd1);
    cyc("busy2", 1, 1, 1, 0, 1, 5'b11100);
    cyc("busy3", 1, 1, 1, 0, 1, 5'b11100);
    cyc("mw_exit", 0, 1, 1, 1, 1, 5'b00000);
    regs("mw_exit", 2'd0, 16'd4, 16'd1);
    cyc("br2", 0, 1, 1, 0, 1, 5'b00001);
    regs("br2", 2'd2, 16'd4, 16'd2);
    cyc("br2_flush2", 0, 0, 1, 0, 1, 5'b00001);
    regs("br2_end", 2'd0, 16'd4, 16'd2);

    // Memory busy during the FLUSH cycle stretches the flush to 4 cycles.
    cyc("br3", 0, 1, 1, 0, 1, 5'b00001);
    regs("br3", 2'd2, 16'd4, 16'd3);
    cyc("fl_busy1", 1, 0, 1, 0, 1, 5'b11101);
    cyc("fl_busy2", 1, 0, 1, 0, 1, 5'b11101);
    regs("fl_busy", 2'd2, 16'd6, 16'd3);
    cyc("fl_last", 0, 0, 1, 0, 1, 5'b00001);
    regs("fl_last", 2'd0, 16'd6, 16'd3);
    cyc("fl_after", 0, 0, 1, 0, 1, 5'b00000);

    // Reset mid-FLUSH and mid-MEM_WAIT.
    cyc("br4", 0, 1, 1, 0, 1, 5'b00001);
    regs("br4", 2'd2, 16'd6, 16'd4);
    rst_n = 1'b0;
    cyc("rst_flush", 1, 1, 1, 1, 1, 5'b00000);
    regs("rst_flush", 2'd0, 16'd0, 16'd0);
    rst_n = 1'b1;
    cyc("mw_enter", 1, 0, 1, 0, 1, 5'b11100);
    regs("mw_enter", 2'd1, 16'd1, 16'd0);
    rst_n = 1'b0;
    cyc("rst_mw", 1, 0, 1, 1, 1, 5'b00000);
    regs("rst_mw", 2'd0, 16'd0, 16'd0);
    rst_n = 1'b1;
    cyc("post_rst_hz", 0, 0, 1, 1, 1, 5'b11010);
    regs("post_rst_hz", 2'd0, 16'd1, 16'd0);

    // Stall counter saturation: a long memory wait from a clean reset.
    rst_n = 1'b0;
    cyc("rst_sat", 0, 0, 1, 0, 1, 5'b00000);
    rst_n = 1'b1;
    hif.mem_busy_i = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 32'(hif.stall_count_o), 32'h0000_FFFE);
    repeat (3) @(posedge clk);
    #1;
    check("sat_ffff", 32'(hif.stall_count_o), 32'h0000_FFFF);
    cyc("sat_hold", 1, 0, 1, 0, 1, 5'b11100);
    regs("sat_hold", 2'd1, 16'hFFFF, 16'd0);
    cyc("sat_exit", 0, 0, 1, 0, 1, 5'b00000);
    regs("sat_exit", 2'd0, 16'hFFFF, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
